el2_lsu_bus_clk_gen: RTL and testbench



---
 rtl/el2_pkg.sv | 11 +
 rtl/el2_lsu_bus_clk_gen.sv | 86 ++++++++
 tb/tb_el2_lsu_bus_clk_gen.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/el2_pkg.sv
// Shared EL2 types and constants used by the LSU bus clock generator.
package el2_pkg;

    localparam int unsigned EL2_BUS_RATIO_W = 3;

    typedef enum logic {
        RUN,
        DRAIN
    } el2_bus_clk_state_t;

endpackage

// File: rtl/el2_lsu_bus_clk_gen.sv
// LSU bus clock-enable generator with programmable core:bus ratio.
// Ratio changes are handshaked and applied only on a bus-clock boundary while the bus is idle.
module el2_lsu_bus_clk_gen
    import el2_pkg::*;
#(
    parameter int unsigned         RATIO_W     = EL2_BUS_RATIO_W,
    parameter logic [RATIO_W-1:0]  RESET_RATIO = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ratio_req_vld,
    input  logic [RATIO_W-1:0] ratio_req_code,
    output logic               ratio_req_rdy,
    input  logic               lsu_bus_buffer_empty_any,
    input  logic               lsu_busreq_r,
    input  logic               dec_tlu_force_halt,
    output logic               lsu_bus_clk_en,
    output logic               lsu_bus_clk_en_q,
    output logic [RATIO_W-1:0] cur_ratio,
    output logic               ratio_chg_done
);

    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic [RATIO_W-1:0] ratio_q, ratio_d;
    logic [RATIO_W-1:0] pend_q, pend_d;
    el2_bus_clk_state_t state_q, state_d;
    logic               en_q, en_d;
    logic               done_q, done_d;
    logic               idle;

    // Compare of flops only, so the enable is glitch-free and has no input-to-output path.
    assign lsu_bus_clk_en   = (cnt_q == ratio_q);
    assign lsu_bus_clk_en_q = en_q;
    assign cur_ratio        = ratio_q;
    assign ratio_chg_done   = done_q;
    assign idle             = lsu_bus_buffer_empty_any & ~lsu_busreq_r;

    always_comb begin
        cnt_d         = lsu_bus_clk_en ? '0 : cnt_q + RATIO_W'(1);
        ratio_d       = ratio_q;
        pend_d        = pend_q;
        state_d       = state_q;
        done_d        = 1'b0;
        en_d          = lsu_bus_clk_en;
        ratio_req_rdy = 1'b0;

        unique case (state_q)
            RUN: begin
                ratio_req_rdy = 1'b1;
                if (ratio_req_vld) begin
                    pend_d  = ratio_req_code;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Apply exactly on the wrap edge so no bus cycle is truncated or stretched.
                if (lsu_bus_clk_en && (idle || dec_tlu_force_halt)) begin
                    ratio_d = pend_q;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            ratio_q <= RESET_RATIO;
            pend_q  <= '0;
            state_q <= RUN;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            pend_q  <= pend_d;
            state_q <= state_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_el2_lsu_bus_clk_gen.sv
// Scoreboard bench for el2_lsu_bus_clk_gen: per-cycle expected outputs are queued and compared.
module tb_el2_lsu_bus_clk_gen;

    typedef struct packed {
        logic       en;
        logic       enq;
        logic       rdy;
        logic [2:0] ratio;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld;
    logic [2:0] code;
    logic       empty;
    logic       busreq;
    logic       halt;

    logic       d3_rdy, d3_en, d3_enq, d3_done;
    logic [2:0] d3_ratio;
    logic       d0_rdy, d0_en, d0_enq, d0_done;
    logic [2:0] d0_ratio;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    el2_lsu_bus_clk_gen #(.RATIO_W(3), .RESET_RATIO(3'd3)) u_dut3 (
        .clk                      (clk),
        .rst                      (rst),
        .ratio_req_vld            (vld),
        .ratio_req_code           (code),
        .ratio_req_rdy            (d3_rdy),
        .lsu_bus_buffer_empty_any (empty),
        .lsu_busreq_r             (busreq),
        .dec_tlu_force_halt       (halt),
        .lsu_bus_clk_en           (d3_en),
        .lsu_bus_clk_en_q         (d3_enq),
        .cur_ratio                (d3_ratio),
        .ratio_chg_done           (d3_done)
    );

    el2_lsu_bus_clk_gen #(.RATIO_W(3), .RESET_RATIO(3'd0)) u_dut0 (
        .clk                      (clk),
        .rst                      (rst),
        .ratio_req_vld            (vld),
        .ratio_req_code           (code),
        .ratio_req_rdy            (d0_rdy),
        .lsu_bus_buffer_empty_any (empty),
        .lsu_busreq_r             (busreq),
        .dec_tlu_force_halt       (halt),
        .lsu_bus_clk_en           (d0_en),
        .lsu_bus_clk_en_q         (d0_enq),
        .cur_ratio                (d0_ratio),
        .ratio_chg_done           (d0_done)
    );

    // Bus-clock pulse at code n, phase counted from cycle 'start'.
    function automatic logic pulse(int c, int start, int n);
        return (c >= start) && (((c - start) % (n + 1)) == n);
    endfunction

    function automatic exp_t obs3();
        return '{en: d3_en, enq: d3_enq, rdy: d3_rdy, ratio: d3_ratio, done: d3_done};
    endfunction

    function automatic exp_t obs0();
        return '{en: d0_en, enq: d0_enq, rdy: d0_rdy, ratio: d0_ratio, done: d0_done};
    endfunction

    task automatic idle_inputs();
        vld    = 1'b0;
        code   = 3'd0;
        empty  = 1'b1;
        busreq = 1'b0;
        halt   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e, got;
        logic prev = 1'b0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            e = '{en: (c % 4) == 3, enq: prev, rdy: 1'b1, ratio: 3'd3, done: 1'b0};
            prev = e.en;
            q.push_back(e);
            @(negedge clk);
            got = obs3();
            e = q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL reset_ratio3 cyc=%0d got=%b exp=%b (en,enq,rdy,ratio,done)",
                         c, got, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_code0();
        exp_t e, got;
        logic prev = 1'b0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            idle_inputs();
            vld  = (c == 2);
            code = 3'd1;
            if (c <= 3) e = '{en: 1'b1, enq: prev, rdy: (c != 3), ratio: 3'd0, done: 1'b0};
            else        e = '{en: pulse(c, 4, 1), enq: prev, rdy: 1'b1, ratio: 3'd1,
                              done: (c == 4)};
            prev = e.en;
            q.push_back(e);
            @(negedge clk);
            got = obs0();
            e = q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL code0_to_1 cyc=%0d got=%b exp=%b (en,enq,rdy,ratio,done)",
                         c, got, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_drain_busy();
        exp_t e, got;
        logic prev = 1'b0;
        do_reset();
        for (int c = 0; c < 26; c++) begin
            idle_inputs();
            vld   = (c == 1);
            code  = 3'd7;
            empty = (c == 0) || (c >= 12);
            if (c <= 15) e = '{en: pulse(c, 0, 3), enq: prev, rdy: (c <= 1), ratio: 3'd3,
                               done: 1'b0};
            else         e = '{en: pulse(c, 16, 7), enq: prev, rdy: 1'b1, ratio: 3'd7,
                               done: (c == 16)};
            prev = e.en;
            q.push_back(e);
            @(negedge clk);
            got = obs3();
            e = q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL drain_busy cyc=%0d got=%b exp=%b (en,enq,rdy,ratio,done)",
                         c, got, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_force_halt();
        exp_t e, got;
        logic prev = 1'b0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            idle_inputs();
            vld   = (c == 1);
            code  = 3'd7;
            empty = (c == 0);
            halt  = (c == 2) || (c == 3);
            if (c <= 3) e = '{en: pulse(c, 0, 3), enq: prev, rdy: (c <= 1), ratio: 3'd3,
                              done: 1'b0};
            else        e = '{en: pulse(c, 4, 7), enq: prev, rdy: 1'b1, ratio: 3'd7,
                              done: (c == 4)};
            prev = e.en;
            q.push_back(e);
            @(negedge clk);
            got = obs3();
            e = q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL force_halt cyc=%0d got=%b exp=%b (en,enq,rdy,ratio,done)",
                         c, got, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Code 5 is held through DRAIN (ignored), then accepted once rdy returns.
    task automatic test_drain_ignore();
        exp_t e, got;
        logic prev = 1'b0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            idle_inputs();
            vld    = (c >= 1) && (c <= 8);
            code   = (c == 1) ? 3'd7 : 3'd5;
            busreq = (c >= 1) && (c <= 3);
            if (c <= 7)       e = '{en: pulse(c, 0, 3), enq: prev, rdy: (c <= 1), ratio: 3'd3,
                                    done: 1'b0};
            else if (c <= 15) e = '{en: pulse(c, 8, 7), enq: prev, rdy: (c == 8), ratio: 3'd7,
                                    done: (c == 8)};
            else              e = '{en: pulse(c, 16, 5), enq: prev, rdy: 1'b1, ratio: 3'd5,
                                    done: (c == 16)};
            prev = e.en;
            q.push_back(e);
            @(negedge clk);
            got = obs3();
            e = q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL drain_ignore cyc=%0d got=%b exp=%b (en,enq,rdy,ratio,done)",
                         c, got, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Reset lands on an idle boundary in DRAIN: reset must win and no apply happens.
    task automatic test_reset_in_drain();
        exp_t e, got;
        logic prev = 1'b0;
        do_reset();
        for (int c = 0; c < 18; c++) begin
            idle_inputs();
            vld   = (c == 1);
            code  = 3'd7;
            empty = (c == 0) || (c >= 7);
            rst   = (c == 7);
            if (c == 8) prev = 1'b0;
            if (c <= 7) e = '{en: pulse(c, 0, 3), enq: prev, rdy: (c <= 1), ratio: 3'd3,
                              done: 1'b0};
            else        e = '{en: pulse(c, 8, 3), enq: prev, rdy: 1'b1, ratio: 3'd3,
                              done: 1'b0};
            prev = e.en;
            q.push_back(e);
            @(negedge clk);
            got = obs3();
            e = q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL reset_in_drain cyc=%0d got=%b exp=%b (en,enq,rdy,ratio,done)",
                         c, got, e);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_code0();
        test_drain_busy();
        test_force_halt();
        test_drain_ignore();
        test_reset_in_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
